sha3_core_arbiter: RTL and testbench
====================================

Name: sha3_core_arbiter

Overview:
Shares one SHA3-256 sponge core (ports in/more/in_valid/out/hash_next/out_valid) between NUM_REQ hash clients, e.g. the HMAC engine and a plain-digest client.
- Grants the core to one requester for a whole multi-block message.
- Registers and forwards that requester's blocks to the core.
- Returns the core's next-block request and final digest to the owner only.
- Sits between the clients and the single SHA3 core instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BLOCK_W, 1088, rate block width in bits
DIGEST_W, 256, digest width in bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  level; requester i wants the core
blk  in  NUM_REQ*BLOCK_W  per-requester block; slice i = blk[i*BLOCK_W +: BLOCK_W]
blk_more  in  NUM_REQ  per-requester: 1 = more blocks follow this one
blk_valid  in  NUM_REQ  per-requester 1-cycle block strobe
gnt  out  NUM_REQ  one-hot grant, level, held for the whole message
nxt  out  NUM_REQ  1-cycle pulse to owner: core accepts the next block
done  out  NUM_REQ  1-cycle pulse to owner: digest valid
digest  out  DIGEST_W  last digest, held until the next done
core_in  out  BLOCK_W  to core in
core_more  out  1  to core more
core_in_valid  out  1  to core in_valid, 1-cycle pulse
core_out  in  DIGEST_W  from core out
core_hash_next  in  1  from core hash_next
core_out_valid  in  1  from core out_valid

Behaviour:
Reset values:
- gnt, nxt, done, core_in_valid, core_more = 0; core_in = 0; digest = 0.
- State = IDLE; round-robin pointer = 0.

All outputs are registered. States:
- IDLE:
  - If any req, select the owner round-robin, starting at the pointer and searching upward with wrap.
  - Register gnt one-hot; go to FIRST.
  - No req: stay in IDLE.
- FIRST: wait for blk_valid[owner].
  - Next cycle: core_in = blk slice, core_more = blk_more, core_in_valid = 1 for one cycle.
  - blk_more = 1: go to WAIT_NEXT. Otherwise go to WAIT_DIGEST.
- WAIT_NEXT:
  - On core_hash_next, pulse nxt[owner] next cycle and go to FEED.
  - core_out_valid in this state is a core protocol violation; ignore it.
- FEED: identical to FIRST (blk_valid[owner] -> forward block -> WAIT_NEXT or WAIT_DIGEST).
- WAIT_DIGEST:
  - On core_out_valid: latch digest = core_out, pulse done[owner] next cycle.
  - Clear gnt in that same cycle.
  - Pointer = owner+1 mod NUM_REQ; go to IDLE.

Latency:
- req to gnt: 1 cycle from IDLE.
- blk_valid to core_in_valid: 1 cycle.
- core_hash_next to nxt: 1 cycle.
- core_out_valid to done/digest: 1 cycle.
- A new grant is possible on the cycle after done, giving back-to-back messages.

Boundary rules:
- blk_valid from a non-owner, or from the owner in WAIT_NEXT/WAIT_DIGEST: ignored, nothing forwarded.
- Owner drops req while granted: no abort; the message completes and done still pulses.
- Simultaneous req from several requesters: round-robin pick only, never two grants.
- req[owner] still high after done: that requester gets the lowest priority in the next round.
- A pointer that is out of range (NUM_REQ not a power of 2) wraps to 0.
- rst_n asserted mid-message returns every register to its reset value immediately. The core shares rst_n.

Optional Feature:
SHA3_ARB_FIXED_PRIO_EN:
- Defined: fixed priority (lowest index wins) and the pointer register is removed. A continuously requesting requester 0 starves the others.
- Undefined: round-robin as above.

Decomposition:
Package sha3_arb_pkg holds:
- the state enum (IDLE, FIRST, WAIT_NEXT, FEED, WAIT_DIGEST);
- default BLOCK_W/DIGEST_W constants.

One sub-module, rr_pick: a combinational round-robin one-hot selector with inputs req and ptr and output one-hot, reused under the FIXED_PRIO variant with ptr tied to 0.

Test Plan:
- Single requester, 2-block message:
  - Stimulus: req[0]=1, block A (more=1), then on nxt block B (more=0); core model answers hash_next, then out_valid with 0xAB..CD.
  - Required: core_in_valid twice with A then B, core_more 1 then 0; done[0] one pulse; digest=0xAB..CD; gnt[0] drops with done.
- Contention:
  - Stimulus: req=2'b11 from IDLE with pointer=0.
  - Required: gnt=01 first; after its done, gnt=10 the next cycle; no overlap.
- Fairness:
  - Stimulus: req held at 2'b11 over 4 messages.
  - Required: grant order 0,1,0,1. With SHA3_ARB_FIXED_PRIO_EN defined, order is 0,0,0,0.
- Illegal strobes:
  - Stimulus: blk_valid[1] while requester 0 owns the core; blk_valid[0] during WAIT_DIGEST.
  - Required: no core_in_valid and no change to core_in.
- Reset mid-message:
  - Stimulus: rst_n low in WAIT_NEXT.
  - Required: gnt=0 and state IDLE immediately; after release, req[1] alone is granted in 1 cycle.

Source files
------------

// File: rtl/sha3_arb_pkg.sv
// Shared types and default widths for the SHA3 core arbiter.
package sha3_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_WAIT_NEXT,
        ST_FEED,
        ST_WAIT_DIGEST
    } arb_state_e;

    localparam int BLOCK_W_DEF  = 1088;
    localparam int DIGEST_W_DEF = 256;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot selector: the first set req at or above
// ptr wins, searching upward with wrap. An out-of-range ptr behaves as 0.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot
);

    always_comb begin
        int p;
        int d;
        int best;
        int sel;
        onehot = '0;
        p      = (int'(ptr) < N) ? int'(ptr) : 0;
        best   = N;
        sel    = 0;
        d      = 0;
        // smallest upward distance from the pointer wins
        for (int i = 0; i < N; i++) begin
            d = (i >= p) ? (i - p) : (i + N - p);
            if (req[i] && (d < best)) begin
                best = d;
                sel  = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            onehot[i] = (best < N) && (sel == i);
        end
    end

endmodule

// File: rtl/sha3_core_arbiter.sv
// Shares one SHA3 sponge core between NUM_REQ clients for whole messages.
// SHA3_ARB_FIXED_PRIO_EN selects fixed priority (lowest index) and drops the pointer.
//
// state          | meaning
// ST_IDLE        | no owner; pick one from req
// ST_FIRST       | owner granted, waiting for its first block
// ST_WAIT_NEXT   | block sent with more=1, waiting for core hash_next
// ST_FEED        | core ready, waiting for the owner's next block
// ST_WAIT_DIGEST | last block sent, waiting for core out_valid
module sha3_core_arbiter
    import sha3_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int BLOCK_W  = BLOCK_W_DEF,
    parameter int DIGEST_W = DIGEST_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BLOCK_W-1:0] blk,
    input  logic [NUM_REQ-1:0]         blk_more,
    input  logic [NUM_REQ-1:0]         blk_valid,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         nxt,
    output logic [NUM_REQ-1:0]         done,
    output logic [DIGEST_W-1:0]        digest,
    output logic [BLOCK_W-1:0]         core_in,
    output logic                       core_more,
    output logic                       core_in_valid,
    input  logic [DIGEST_W-1:0]        core_out,
    input  logic                       core_hash_next,
    input  logic                       core_out_valid
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  nxt_q, nxt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [BLOCK_W-1:0]  core_in_q, core_in_d;
    logic                core_more_q, core_more_d;
    logic                core_in_valid_q, core_in_valid_d;

    logic [NUM_REQ-1:0]  pick;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       ptr_w;
    logic [BLOCK_W-1:0]  blk_sel;
    logic                blk_more_sel;
    logic                blk_valid_sel;

`ifdef SHA3_ARB_FIXED_PRIO_EN
    assign ptr_w = '0;
`else
    logic [PW-1:0] ptr_q, ptr_d;
    assign ptr_w = ptr_q;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_w),
        .onehot (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    // Only the owner's lane is visible; other strobes never reach the FSM.
    always_comb begin
        blk_sel       = '0;
        blk_more_sel  = 1'b0;
        blk_valid_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PW'(i)) begin
                blk_sel       = blk[i*BLOCK_W +: BLOCK_W];
                blk_more_sel  = blk_more[i];
                blk_valid_sel = blk_valid[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        owner_d         = owner_q;
        nxt_d           = '0;
        done_d          = '0;
        digest_d        = digest_q;
        core_in_d       = core_in_q;
        core_more_d     = core_more_q;
        core_in_valid_d = 1'b0;
`ifndef SHA3_ARB_FIXED_PRIO_EN
        ptr_d           = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST, ST_FEED: begin
                if (blk_valid_sel) begin
                    core_in_d       = blk_sel;
                    core_more_d     = blk_more_sel;
                    core_in_valid_d = 1'b1;
                    state_d         = blk_more_sel ? ST_WAIT_NEXT : ST_WAIT_DIGEST;
                end
            end
            ST_WAIT_NEXT: begin
                // a stray core_out_valid here is a core fault and is dropped
                if (core_hash_next) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        nxt_d[i] = (owner_q == PW'(i));
                    end
                    state_d = ST_FEED;
                end
            end
            ST_WAIT_DIGEST: begin
                if (core_out_valid) begin
                    digest_d = core_out;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        done_d[i] = (owner_q == PW'(i));
                    end
                    gnt_d   = '0;
`ifndef SHA3_ARB_FIXED_PRIO_EN
                    ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            gnt_q           <= '0;
            owner_q         <= '0;
            nxt_q           <= '0;
            done_q          <= '0;
            digest_q        <= '0;
            core_in_q       <= '0;
            core_more_q     <= 1'b0;
            core_in_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            owner_q         <= owner_d;
            nxt_q           <= nxt_d;
            done_q          <= done_d;
            digest_q        <= digest_d;
            core_in_q       <= core_in_d;
            core_more_q     <= core_more_d;
            core_in_valid_q <= core_in_valid_d;
        end
    end

`ifndef SHA3_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    assign gnt           = gnt_q;
    assign nxt           = nxt_q;
    assign done          = done_q;
    assign digest        = digest_q;
    assign core_in       = core_in_q;
    assign core_more     = core_more_q;
    assign core_in_valid = core_in_valid_q;

endmodule

// File: tb/tb_sha3_core_arbiter.sv
// Directed bench for sha3_core_arbiter with a hand-driven core model.
module tb_sha3_core_arbiter;

    localparam int NR = 2;
    localparam int BW = 1088;
    localparam int DW = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*BW-1:0]  blk;
    logic [NR-1:0]     blk_more;
    logic [NR-1:0]     blk_valid;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     nxt;
    logic [NR-1:0]     done;
    logic [DW-1:0]     digest;
    logic [BW-1:0]     core_in;
    logic              core_more;
    logic              core_in_valid;
    logic [DW-1:0]     core_out;
    logic              core_hash_next;
    logic              core_out_valid;

    int n_chk  = 0;
    int n_pass = 0;
    logic [BW-1:0] last_blk;

    always #5 clk = ~clk;

    sha3_core_arbiter #(.NUM_REQ(NR), .BLOCK_W(BW), .DIGEST_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .blk            (blk),
        .blk_more       (blk_more),
        .blk_valid      (blk_valid),
        .gnt            (gnt),
        .nxt            (nxt),
        .done           (done),
        .digest         (digest),
        .core_in        (core_in),
        .core_more      (core_more),
        .core_in_valid  (core_in_valid),
        .core_out       (core_out),
        .core_hash_next (core_hash_next),
        .core_out_valid (core_out_valid)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [BW-1:0] mk_blk(input logic [31:0] w);
        return {34{w}};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // One single-block message for the owner exp_g, entered with gnt already registered.
    task automatic msg1(input logic [1:0] exp_g, input logic [31:0] w, input logic [DW-1:0] dg);
        int o;
        logic [BW-1:0] b;
        o = exp_g[1] ? 1 : 0;
        b = mk_blk(w);
        chk("msg_gnt", 256'(gnt), 256'(exp_g));
        blk_valid = ~exp_g;
        blk[(1-o)*BW +: BW] = mk_blk(32'hDEAD_0000 | w);
        blk_more = 2'b11;
        step();
        blk_valid = 2'b00;
        chk("nonowner_strobe_valid", 256'(core_in_valid), 256'(0));
        chk("nonowner_strobe_data", core_in[255:0], last_blk[255:0]);
        blk[o*BW +: BW] = b;
        blk_more = 2'b00;
        blk_valid = exp_g;
        step();
        blk_valid = 2'b00;
        last_blk = b;
        chk("msg_in_valid", 256'(core_in_valid), 256'(1));
        chk("msg_in_data", core_in[255:0], b[255:0]);
        chk("msg_more", 256'(core_more), 256'(0));
        core_out = dg;
        core_out_valid = 1'b1;
        step();
        core_out_valid = 1'b0;
        chk("msg_done", 256'(done), 256'(exp_g));
        chk("msg_gnt_drop", 256'(gnt), 256'(0));
        chk("msg_digest", digest, dg);
    endtask

    initial begin
        logic [BW-1:0] blk_a, blk_b;
        logic [DW-1:0] d1;
        logic [1:0] ord [4];
        blk_a = mk_blk(32'hA000_0001);
        blk_b = mk_blk(32'hB000_0002);
        d1    = {8'hAB, {30{8'h5A}}, 8'hCD};
        last_blk = '0;
`ifdef SHA3_ARB_FIXED_PRIO_EN
        ord = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        ord = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        rst_n = 1'b0;
        req = '0; blk = '0; blk_more = '0; blk_valid = '0;
        core_out = '0; core_hash_next = 1'b0; core_out_valid = 1'b0;
        step();
        step();
        chk("rst_gnt", 256'(gnt), 256'(0));
        chk("rst_in_valid", 256'(core_in_valid), 256'(0));
        chk("rst_more", 256'(core_more), 256'(0));
        chk("rst_core_in", core_in[255:0], 256'(0));
        chk("rst_digest", digest, 256'(0));
        chk("rst_done_nxt", 256'({done, nxt}), 256'(0));

        // single requester, two-block message
        rst_n = 1'b1;
        req = 2'b01;
        step();
        chk("t1_gnt", 256'(gnt), 256'(2'b01));
        blk[0 +: BW] = blk_a; blk_more = 2'b01; blk_valid = 2'b01;
        step();
        blk_valid = 2'b00;
        chk("t1_a_valid", 256'(core_in_valid), 256'(1));
        chk("t1_a_data", core_in[255:0], blk_a[255:0]);
        chk("t1_a_more", 256'(core_more), 256'(1));
        core_hash_next = 1'b1;
        step();
        core_hash_next = 1'b0;
        chk("t1_nxt", 256'(nxt), 256'(2'b01));
        chk("t1_no_repeat", 256'(core_in_valid), 256'(0));
        blk[0 +: BW] = blk_b; blk_more = 2'b00; blk_valid = 2'b01;
        step();
        blk_valid = 2'b00;
        chk("t1_nxt_pulse", 256'(nxt), 256'(0));
        chk("t1_b_valid", 256'(core_in_valid), 256'(1));
        chk("t1_b_data", core_in[255:0], blk_b[255:0]);
        chk("t1_b_more", 256'(core_more), 256'(0));
        blk[0 +: BW] = mk_blk(32'hCCCC_0003); blk_valid = 2'b01;
        step();
        blk_valid = 2'b00;
        chk("t1_wd_strobe_valid", 256'(core_in_valid), 256'(0));
        chk("t1_wd_strobe_data", core_in[255:0], blk_b[255:0]);
        req = 2'b00;
        core_out = d1; core_out_valid = 1'b1;
        step();
        core_out_valid = 1'b0;
        chk("t1_done", 256'(done), 256'(2'b01));
        chk("t1_digest", digest, d1);
        chk("t1_gnt_drop", 256'(gnt), 256'(0));
        core_out = '0;
        step();
        chk("t1_done_pulse", 256'(done), 256'(0));
        chk("t1_digest_hold", digest, d1);
        chk("t1_idle_gnt", 256'(gnt), 256'(0));

        // contention and fairness from a fresh pointer of 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        last_blk = '0;
        req = 2'b11;
        step();
        for (int m = 0; m < 4; m++) begin
            msg1(ord[m], 32'h1000_0000 + 32'(m), {8'h0F, 240'(m), 8'hF0});
            if (m == 3) req = 2'b00;
            step();
        end
        chk("fair_end_idle", 256'(gnt), 256'(0));

        // reset in WAIT_NEXT
        req = 2'b01;
        step();
        chk("rm_gnt", 256'(gnt), 256'(2'b01));
        blk[0 +: BW] = blk_a; blk_more = 2'b01; blk_valid = 2'b01;
        step();
        blk_valid = 2'b00;
        chk("rm_sent", 256'(core_in_valid), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("rm_async_gnt", 256'(gnt), 256'(0));
        chk("rm_async_core_in", core_in[255:0], 256'(0));
        chk("rm_async_digest", digest, 256'(0));
        step();
        rst_n = 1'b1;
        req = 2'b10;
        step();
        chk("rm_regrant", 256'(gnt), 256'(2'b10));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
